pu_riscv_pmpcsr: RTL and testbench

PMP CSR register file for the PU-RISCV core: holds `pmpcfg`/`pmpaddr` state, executes M-mode CSR read/write/set/clear accesses with WARL legalisation and lock semantics, and drives the registered `st_pmpcfg_o`/`st_pmpaddr_o` buses consumed by the PMP checkers in the instruction and data memory paths. It is the producer side of the PMP state interface; the checkers are purely combinational consumers.

---
 rtl/pu_riscv_verilog_pkg.sv | 31 +++
 rtl/pu_riscv_pmpcfg_legalize.sv | 25 ++
 rtl/pu_riscv_pmpcsr.sv | 162 ++++++++++++++++
 tb/tb_pu_riscv_pmpcsr.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pu_riscv_verilog_pkg.sv
// Shared PU-RISCV definitions used by the PMP CSR block: CSR addresses,
// CSR access opcodes, PMP address-matching modes and privilege levels.
package pu_riscv_verilog_pkg;

    // Base CSR addresses of the PMP register groups
    localparam logic [11:0] PMPCFG0  = 12'h3A0;
    localparam logic [11:0] PMPADDR0 = 12'h3B0;

    // Privilege levels
    localparam logic [1:0] PRV_U = 2'd0;
    localparam logic [1:0] PRV_S = 2'd1;
    localparam logic [1:0] PRV_H = 2'd2;
    localparam logic [1:0] PRV_M = 2'd3;

    // CSR access operations
    typedef enum logic [1:0] {
        CSR_READ = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_op_t;

    // PMP address-matching mode (cfg bits [4:3])
    typedef enum logic [1:0] {
        OFF   = 2'd0,
        TOR   = 2'd1,
        NA4   = 2'd2,
        NAPOT = 2'd3
    } pmp_a_t;

endpackage

// File: rtl/pu_riscv_pmpcfg_legalize.sv
// Per-byte WARL filter for a pmpcfg entry: honours the lock bit, clears the
// reserved bits [6:5] and rejects the reserved R=0/W=1 permission pair.
module pu_riscv_pmpcfg_legalize (
    input  logic [7:0] old_i,
    input  logic [7:0] new_i,
    input  logic       lock_i,
    output logic [7:0] next_o
);

    logic [7:0] masked;

    // Pick the byte that the entry will hold after this write
    always_comb begin
        masked = new_i & 8'h9F;
        if (lock_i) begin
            next_o = old_i;
        end else if (!masked[0] && masked[1]) begin
            // write-only without read is reserved: keep the whole old byte
            next_o = old_i;
        end else begin
            next_o = masked;
        end
    end

endmodule

// File: rtl/pu_riscv_pmpcsr.sv
// PMP CSR register file: holds pmpcfg/pmpaddr state, serves M-mode CSR
// read/write/set/clear accesses with WARL legalisation and locking, and
// publishes the registered state to the PMP checkers.
module pu_riscv_pmpcsr
    import pu_riscv_verilog_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int PLEN    = 64,
    parameter int PMP_CNT = 16
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [1:0]                                   st_prv_i,
    input  logic                                         csr_req_i,
    input  logic [11:0]                                  csr_adr_i,
    input  logic [1:0]                                   csr_op_i,
    input  logic [XLEN-1:0]                              csr_wdata_i,
    output logic                                         csr_ack_o,
    output logic [XLEN-1:0]                              csr_rdata_o,
    output logic                                         csr_illegal_o,
    output logic [(PMP_CNT > 0 ? PMP_CNT : 1)*8-1:0]     st_pmpcfg_o,
    output logic [(PMP_CNT > 0 ? PMP_CNT : 1)*XLEN-1:0]  st_pmpaddr_o,
    output logic                                         pmp_update_o
);

    localparam int NB = XLEN / 8;
    // Stored address width; never wider than the CSR itself
    localparam int AW = (PLEN - 2 < XLEN) ? PLEN - 2 : XLEN;

    // Architectural state; entries at or above PMP_CNT are never written
    logic [7:0]      cfg_q  [16];
    logic [7:0]      cfg_d  [16];
    logic [AW-1:0]   addr_q [16];
    logic [AW-1:0]   addr_d [16];

    logic            ack_q, ack_d;
    logic            ill_q, ill_d;
    logic            upd_q, upd_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic            is_cfg, is_addr, legal, do_wr, addr_locked;
    logic [3:0]      cfg_base, addr_idx;
    logic [XLEN-1:0] old_val, new_val;
    logic [7:0]      leg_byte [NB];

    // Decode the address, fetch the pre-write value and merge the operand
    always_comb begin
        // RV64 packs eight entries per register, so odd pmpcfg numbers vanish
        is_cfg   = (csr_adr_i[11:2] == PMPCFG0[11:2]) && ((XLEN == 32) || !csr_adr_i[0]);
        is_addr  = (csr_adr_i[11:4] == PMPADDR0[11:4]);
        legal    = (is_cfg || is_addr) && (st_prv_i == PRV_M);
        cfg_base = {csr_adr_i[1:0], 2'b00};
        addr_idx = csr_adr_i[3:0];

        old_val = '0;
        if (is_cfg) begin
            for (int j = 0; j < NB; j++) begin
                old_val[j*8 +: 8] = cfg_q[cfg_base + 4'(j)];
            end
        end else if (is_addr) begin
            old_val = XLEN'(addr_q[addr_idx]);
        end

        case (csr_op_i)
            CSR_RW:  new_val = csr_wdata_i;
            CSR_RS:  new_val = old_val | csr_wdata_i;
            CSR_RC:  new_val = old_val & ~csr_wdata_i;
            default: new_val = old_val;
        endcase

        // Set/clear with an empty mask is a pure read
        do_wr = csr_req_i && legal &&
                ((csr_op_i == CSR_RW) ||
                 (((csr_op_i == CSR_RS) || (csr_op_i == CSR_RC)) && (|csr_wdata_i)));

        // A TOR region above also pins this entry's address as its base
        addr_locked = cfg_q[addr_idx][7] ||
                      ((int'(addr_idx) + 1 < PMP_CNT) &&
                       cfg_q[addr_idx + 4'd1][7] &&
                       (cfg_q[addr_idx + 4'd1][4:3] == TOR));
    end

    // One legaliser per byte lane of the accessed pmpcfg register
    for (genvar j = 0; j < NB; j++) begin : g_leg
        pu_riscv_pmpcfg_legalize u_leg (
            .old_i  (old_val[j*8 +: 8]),
            .new_i  (new_val[j*8 +: 8]),
            .lock_i (old_val[j*8 + 7]),
            .next_o (leg_byte[j])
        );
    end

    // Compute next state, response and the change-detect pulse
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            cfg_d[i]  = cfg_q[i];
            addr_d[i] = addr_q[i];
        end

        if (do_wr && is_cfg) begin
            for (int j = 0; j < NB; j++) begin
                if (int'(cfg_base) + j < PMP_CNT) begin
                    cfg_d[cfg_base + 4'(j)] = leg_byte[j];
                end
            end
        end

        if (do_wr && is_addr && (int'(addr_idx) < PMP_CNT) && !addr_locked) begin
            addr_d[addr_idx] = new_val[AW-1:0];
        end

        upd_d = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if ((cfg_d[i] != cfg_q[i]) || (addr_d[i] != addr_q[i])) begin
                upd_d = 1'b1;
            end
        end

        ack_d   = csr_req_i;
        ill_d   = csr_req_i && !legal;
        rdata_d = (csr_req_i && legal) ? old_val : '0;
    end

    // State and response registers; a request during reset is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                cfg_q[i]  <= '0;
                addr_q[i] <= '0;
            end
            ack_q   <= 1'b0;
            ill_q   <= 1'b0;
            upd_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                cfg_q[i]  <= cfg_d[i];
                addr_q[i] <= addr_d[i];
            end
            ack_q   <= ack_d;
            ill_q   <= ill_d;
            upd_q   <= upd_d;
            rdata_q <= rdata_d;
        end
    end

    assign csr_ack_o     = ack_q;
    assign csr_illegal_o = ill_q;
    assign csr_rdata_o   = rdata_q;
    assign pmp_update_o  = upd_q;

    if (PMP_CNT == 0) begin : g_none
        assign st_pmpcfg_o  = '0;
        assign st_pmpaddr_o = '0;
    end else begin : g_out
        for (genvar i = 0; i < PMP_CNT; i++) begin : g_ent
            assign st_pmpcfg_o[i*8 +: 8]        = cfg_q[i];
            assign st_pmpaddr_o[i*XLEN +: XLEN] = XLEN'(addr_q[i]);
        end
    end

endmodule

// File: tb/tb_pu_riscv_pmpcsr.sv
// Bench for pu_riscv_pmpcsr (XLEN=64, PLEN=64, PMP_CNT=16): directed CSR
// accesses, a behavioural model of the PMP CSR state checked every cycle,
// and literal expectations for the key scenarios.
module tb_pu_riscv_pmpcsr;
    import pu_riscv_verilog_pkg::*;

    localparam int XLEN    = 64;
    localparam int PLEN    = 64;
    localparam int PMP_CNT = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    prv;
    logic          req;
    logic [11:0]   adr;
    logic [1:0]    op;
    logic [63:0]   wdata;
    logic          ack;
    logic [63:0]   rdata;
    logic          ill;
    logic [127:0]  cfg_o;
    logic [1023:0] addr_o;
    logic          upd;

    always #5 clk = ~clk;

    pu_riscv_pmpcsr #(.XLEN(XLEN), .PLEN(PLEN), .PMP_CNT(PMP_CNT)) dut (
        .clk           (clk),
        .rst           (rst),
        .st_prv_i      (prv),
        .csr_req_i     (req),
        .csr_adr_i     (adr),
        .csr_op_i      (op),
        .csr_wdata_i   (wdata),
        .csr_ack_o     (ack),
        .csr_rdata_o   (rdata),
        .csr_illegal_o (ill),
        .st_pmpcfg_o   (cfg_o),
        .st_pmpaddr_o  (addr_o),
        .pmp_update_o  (upd)
    );

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_cfg  [16];
    logic [63:0] m_addr [16];
    logic        e_ack, e_ill, e_upd;
    logic [63:0] e_rdata;

    always @(posedge clk) begin : model
        automatic logic [7:0]  nc [16];
        automatic logic [63:0] na [16];
        automatic logic [63:0] old, nv;
        automatic logic [7:0]  nb;
        automatic bit          isc, isa, wr, chg, locked;
        automatic int          base, idx;
        base = 0;
        idx  = 0;
        for (int i = 0; i < 16; i++) begin
            nc[i] = m_cfg[i];
            na[i] = m_addr[i];
        end
        e_ack   <= 1'b0;
        e_ill   <= 1'b0;
        e_upd   <= 1'b0;
        e_rdata <= 64'd0;
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_cfg[i]  <= 8'd0;
                m_addr[i] <= 64'd0;
            end
        end else if (req) begin
            isc = (prv == PRV_M) && (adr == 12'h3A0 || adr == 12'h3A2);
            isa = (prv == PRV_M) && (adr >= 12'h3B0) && (adr <= 12'h3BF);
            e_ack <= 1'b1;
            if (!isc && !isa) begin
                e_ill <= 1'b1;
            end else begin
                old = 64'd0;
                if (isc) begin
                    base = (adr == 12'h3A2) ? 8 : 0;
                    for (int b = 0; b < 8; b++) old = old | (64'(m_cfg[base + b]) << (8 * b));
                end else begin
                    idx = int'(adr) - 'h3B0;
                    old = m_addr[idx];
                end
                e_rdata <= old;
                case (op)
                    2'd1:    nv = wdata;
                    2'd2:    nv = old | wdata;
                    2'd3:    nv = old & ~wdata;
                    default: nv = old;
                endcase
                wr = (op == 2'd1) || ((op >= 2'd2) && (wdata != 64'd0));
                if (wr && isc) begin
                    for (int b = 0; b < 8; b++) begin
                        nb = 8'((nv >> (8 * b)) & 64'h9F);
                        if (!m_cfg[base + b][7] && !(nb[1:0] == 2'b10)) nc[base + b] = nb;
                    end
                end
                if (wr && isa) begin
                    locked = m_cfg[idx][7] ||
                             ((idx < 15) && m_cfg[idx + 1][7] && (m_cfg[idx + 1][4:3] == 2'b01));
                    if (!locked) na[idx] = nv & 64'h3FFF_FFFF_FFFF_FFFF;
                end
                chg = 1'b0;
                for (int i = 0; i < 16; i++) begin
                    if (nc[i] != m_cfg[i] || na[i] != m_addr[i]) chg = 1'b1;
                end
                e_upd <= chg;
                for (int i = 0; i < 16; i++) begin
                    m_cfg[i]  <= nc[i];
                    m_addr[i] <= na[i];
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("ack", 64'(ack), 64'(e_ack));
            check("illegal", 64'(ill), 64'(e_ill));
            check("update", 64'(upd), 64'(e_upd));
            if (e_ack) check("rdata", rdata, e_rdata);
            for (int i = 0; i < 16; i++) begin
                check($sformatf("cfg%0d", i), 64'(cfg_o[i*8 +: 8]), 64'(m_cfg[i]));
                check($sformatf("addr%0d", i), addr_o[i*64 +: 64], m_addr[i]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic acc(input logic [1:0] p, input logic [11:0] a, input logic [1:0] o,
                       input logic [63:0] w);
        prv   = p;
        adr   = a;
        op    = o;
        wdata = w;
        req   = 1'b1;
        @(negedge clk);
        req   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; prv = PRV_M; adr = 12'd0; op = 2'd0; wdata = 64'd0;
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        acc(PRV_M, 12'h3A0, 2'd0, 64'd0);
        check("lit_rd_ack", 64'(ack), 64'd1);
        check("lit_rd_data", rdata, 64'd0);
        check("lit_rd_ill", 64'(ill), 64'd0);

        acc(PRV_M, 12'h3B0, 2'd1, 64'h1000_0000);
        check("lit_addr0", addr_o[63:0], 64'h1000_0000);
        check("lit_upd_addr0", 64'(upd), 64'd1);

        acc(PRV_M, 12'h3A0, 2'd1, 64'h0F);
        check("lit_cfg0", 64'(cfg_o[7:0]), 64'h0F);
        check("lit_upd_cfg0", 64'(upd), 64'd1);

        acc(PRV_M, 12'h3A0, 2'd1, 64'h8F0F);
        check("lit_cfg1_lock", 64'(cfg_o[15:8]), 64'h8F);
        check("lit_upd_lock", 64'(upd), 64'd1);

        acc(PRV_M, 12'h3B0, 2'd1, 64'h2000);
        check("lit_tor_locked_addr", addr_o[63:0], 64'h1000_0000);
        check("lit_tor_locked_upd", 64'(upd), 64'd0);
        check("lit_tor_locked_rd", rdata, 64'h1000_0000);

        acc(PRV_M, 12'h3A0, 2'd3, 64'h8000);
        check("lit_rc_locked", 64'(cfg_o[15:0]), 64'h8F0F);
        check("lit_rc_upd", 64'(upd), 64'd0);

        acc(PRV_M, 12'h3A0, 2'd1, 64'h62);
        check("lit_reserved_wr", 64'(cfg_o[15:0]), 64'h8F0F);
        check("lit_reserved_upd", 64'(upd), 64'd0);
        acc(PRV_M, 12'h3A0, 2'd1, 64'h63);
        check("lit_bits65_cleared", 64'(cfg_o[15:0]), 64'h8F03);

        acc(PRV_M, 12'h3B2, 2'd1, 64'd5);
        acc(PRV_M, 12'h3B2, 2'd0, 64'd0);
        check("lit_b2b_rd", rdata, 64'd5);

        acc(PRV_M, 12'h3A0, 2'd1, 64'h0000_0000_0B8D_0003);
        check("lit_multi_byte", 64'(cfg_o[31:0]), 64'h0B8D_8F03);
        acc(PRV_M, 12'h3B2, 2'd1, 64'd7);
        check("lit_own_lock", addr_o[2*64 +: 64], 64'd5);
        acc(PRV_M, 12'h3B1, 2'd1, 64'd9);
        acc(PRV_M, 12'h3B3, 2'd1, 64'h33);
        check("lit_addr3", addr_o[3*64 +: 64], 64'h33);

        acc(PRV_M, 12'h3A1, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("lit_odd_cfg_ill", 64'(ill), 64'd1);
        check("lit_odd_cfg_rd", rdata, 64'd0);
        acc(PRV_U, 12'h3A0, 2'd1, 64'd0);
        check("lit_umode_ill", 64'(ill), 64'd1);
        acc(PRV_M, 12'h300, 2'd0, 64'd0);
        acc(PRV_M, 12'h3A2, 2'd1, 64'h0707_0707_0707_0707);
        acc(PRV_M, 12'h3B3, 2'd2, 64'd0);
        check("lit_rs_zero_upd", 64'(upd), 64'd0);
        acc(PRV_M, 12'h3B5, 2'd2, 64'hF0);
        acc(PRV_M, 12'h3B4, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("lit_plen_trunc", addr_o[4*64 +: 64], 64'h3FFF_FFFF_FFFF_FFFF);
        acc(PRV_M, 12'h3B6, 2'd0, 64'hAA);

        // reset in the middle of traffic, with a request on the same edge
        prv = PRV_M; adr = 12'h3B6; op = 2'd1; wdata = 64'h77; req = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        check("lit_rst_ack", 64'(ack), 64'd0);
        check("lit_rst_cfg", 64'(|cfg_o), 64'd0);
        check("lit_rst_addr", 64'(|addr_o), 64'd0);

        acc(PRV_M, 12'h3A0, 2'd1, 64'h0F0F);
        check("lit_lock_cleared", 64'(cfg_o[15:0]), 64'h0F0F);
        acc(PRV_M, 12'h3A0, 2'd0, 64'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
